alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Instruction sequencer that drives the 8-bit ALU (opcodes 0-5: OR, NAND, NOR, AND, ADD, SUB).
//  Fetches 8-bit words from a synchronous program ROM and decodes them. Issues ALU operations on
//  its register file and moves data between registers and I/O ports. Branches on the ALU result.
//  Sits between program ROM, ALU and the ready/valid I/O ports.
// PARAMETERS
//  UUID      0   instance identifier, XORed into child UUIDs
//  NAME      ""  instance name
//  RESET_PC  0   8-bit program address fetched first after reset
// PORTS
//  clk              in   1  clock, all state on rising edge
//  rst              in   1  asynchronous, active-low reset
//  prog_addr        out  8  ROM address (= PC)
//  prog_data        in   8  ROM word, valid the cycle after prog_addr is presented
//  alu_instruction  out  8  to ALU Instruction, {5'b0, op}
//  alu_input_1      out  8  to ALU Input_1, always reg1
//  alu_input_2      out  8  to ALU Input_2, always reg2
//  alu_output       in   8  from ALU Output (combinational)
//  in_data          in   8  input port byte
//  in_valid         in   1  input byte available
//  in_ready         out  1  sequencer accepts in_data
//  out_data         out  8  output port byte
//  out_valid        out  1  out_data valid
//  out_ready        in   1  sink accepts out_data
// BEHAVIOUR
//  Register file and reset
//  - Registers reg0..reg5, 8 bits each.
//  - rst low clears immediately: reg0..5=0, PC=RESET_PC, state=FETCH, out_valid=0, out_data=0,
//    in_ready=0, alu_instruction=0.
//  - Reset mid-handshake abandons the transfer; no partial register write occurs.
//  Instruction set (decoded in EXEC)
//  - 00iiiiii IMM:  reg0 <= {2'b00,i}
//  - 01xxxooo CALC: alu_instruction={5'b0,o}; reg3 <= alu_output in the same EXEC cycle.
//    o=6/7: the ALU returns 0, so reg3 <= 0.
//  - 10sssddd COPY: src s, dst d.
//    0-5 = reg0-5; s=6 reads the input port, d=6 writes the output port;
//    s=7 reads 0, d=7 discards.
//  - 11xxxccc COND: test reg3 as signed. 0 never, 1 ==0, 2 <0, 3 <=0, 4 always, 5 !=0, 6 >=0, 7 >0.
//    True: PC <= reg0. False: PC <= PC+1.
//  - Every non-branching instruction ends with PC <= PC+1, wrapping 255 -> 0.
//  - x bits ignored.
//  FSM states and transitions
//  - FETCH -> EXEC, always.
//  - EXEC -> WAIT_IN (COPY with s=6), WAIT_OUT (COPY with s!=6, d=6), else FETCH.
//  - WAIT_IN: in_ready=1. On in_valid&in_ready, capture byte.
//    d=6 -> WAIT_OUT with the captured byte; else write dst, PC+1 -> FETCH.
//  - WAIT_OUT: out_valid=1; out_data held stable until out_ready. On handshake: out_valid <= 0,
//    PC+1 -> FETCH.
//  Timing
//  - Latency: 2 cycles per IMM/CALC/COND/reg-to-reg COPY. I/O stalls indefinitely with no timeout.
//  - in_ready is high only in WAIT_IN. out_valid may not drop before handshake.
//  - in_valid while not in WAIT_IN is ignored, not buffered.
//  - COPY d==s (same reg) is a legal no-op write.
//  - COND with reg0 == PC loops on itself; legal halt idiom.
//  - alu_input_1/2 track reg1/reg2 combinationally in all states.
// TESTING
//  - Reset: rst low mid-WAIT_OUT -> out_valid=0, prog_addr=RESET_PC, all regs 0 after release.
//  - ROM 0x05,0x81,0x1A,0x82,0x44 -> reg1=5, reg2=26, ADD gives reg3=31; 10 cycles to next fetch.
//  - reg1=3, reg2=5, CALC op5 (SUB) -> reg3=0xFE.
//    Then COND 0x*2 (<0) with reg0=0x10 -> prog_addr=0x10.
//    COND 0x*7 -> PC+1.
//  - COPY 0xB6 (in->out):
//    - in_valid delayed 3 cycles -> in_ready held.
//    - byte 0xA5 appears on out_data.
//    - out_ready low 4 cycles -> out_valid and 0xA5 stay stable; PC+1 only after handshake.
//  - PC=255 running IMM -> next prog_addr=0. COND "always" with reg0=PC -> PC frozen.
//  - CALC op6/op7 -> reg3=0. COPY 0xB8 (s=7) -> reg0=0.
//    COPY 0x87 (d=7) -> no register change.
//    in_valid pulsed during FETCH is ignored.

Source files
------------

// File: rtl/alu_sequencer.sv
// Instruction sequencer for the 8-bit ALU.
// Fetches a word from a synchronous program ROM and decodes it on the following cycle. It
// executes IMM/CALC/COPY/COND instructions on a six-entry register file and moves bytes over
// ready/valid I/O ports.
module alu_sequencer #(
  parameter int unsigned UUID     = 0,
  parameter string       NAME     = "",
  parameter logic [7:0]  RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] prog_addr,
  input  logic [7:0] prog_data,
  output logic [7:0] alu_instruction,
  output logic [7:0] alu_input_1,
  output logic [7:0] alu_input_2,
  input  logic [7:0] alu_output,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready
);

  typedef enum logic [1:0] {
    StFetch,
    StExec,
    StWaitIn,
    StWaitOut
  } state_e;

  // Instruction classes in prog_data[7:6]
  localparam logic [1:0] ClsImm  = 2'b00;
  localparam logic [1:0] ClsCalc = 2'b01;
  localparam logic [1:0] ClsCopy = 2'b10;

  // COPY selector values with special meaning
  localparam logic [2:0] SelPort = 3'd6;

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] regs_q [6];
  logic [7:0] regs_d [6];
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic [2:0] dst_q, dst_d;

  logic [1:0] op_cls;
  logic [5:0] imm;
  logic [2:0] fld_hi;
  logic [2:0] fld_lo;
  logic [7:0] pc_inc;
  logic [7:0] src_val;
  logic       cond_true;

  // Field extraction; prog_data is only meaningful while in StExec
  always_comb begin
    op_cls = prog_data[7:6];
    imm    = prog_data[5:0];
    fld_hi = prog_data[5:3];
    fld_lo = prog_data[2:0];
    pc_inc = pc_q + 8'd1;
  end

  // COPY source read: reg0..reg5, selector 7 reads zero (6 is handled via StWaitIn)
  always_comb begin
    src_val = '0;
    for (int i = 0; i < 6; i++) begin
      if (fld_hi == 3'(i)) begin
        src_val = regs_q[i];
      end
    end
  end

  // Branch condition on reg3 interpreted as a signed byte
  always_comb begin
    logic zero;
    logic neg;
    zero = (regs_q[3] == 8'h00);
    neg  = regs_q[3][7];
    cond_true = 1'b0;
    case (fld_lo)
      3'd0: cond_true = 1'b0;
      3'd1: cond_true = zero;
      3'd2: cond_true = neg;
      3'd3: cond_true = neg | zero;
      3'd4: cond_true = 1'b1;
      3'd5: cond_true = ~zero;
      3'd6: cond_true = ~neg;
      default: cond_true = ~neg & ~zero;
    endcase
  end

  // Next-state, register-file updates and ALU opcode drive
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    regs_d          = regs_q;
    out_data_d      = out_data_q;
    out_valid_d     = out_valid_q;
    dst_d           = dst_q;
    alu_instruction = '0;

    unique case (state_q)
      StFetch: begin
        state_d = StExec;
      end

      StExec: begin
        case (op_cls)
          ClsImm: begin
            regs_d[0] = {2'b00, imm};
            pc_d      = pc_inc;
            state_d   = StFetch;
          end
          ClsCalc: begin
            // ALU is combinational: result is captured in this same cycle
            alu_instruction = {5'b00000, fld_lo};
            regs_d[3]       = alu_output;
            pc_d            = pc_inc;
            state_d         = StFetch;
          end
          ClsCopy: begin
            dst_d = fld_lo;
            if (fld_hi == SelPort) begin
              state_d = StWaitIn;
            end else if (fld_lo == SelPort) begin
              out_data_d  = src_val;
              out_valid_d = 1'b1;
              state_d     = StWaitOut;
            end else begin
              // Destination 7 matches no register and is discarded
              for (int i = 0; i < 6; i++) begin
                if (fld_lo == 3'(i)) begin
                  regs_d[i] = src_val;
                end
              end
              pc_d    = pc_inc;
              state_d = StFetch;
            end
          end
          default: begin
            pc_d    = cond_true ? regs_q[0] : pc_inc;
            state_d = StFetch;
          end
        endcase
      end

      StWaitIn: begin
        if (in_valid) begin
          if (dst_q == SelPort) begin
            out_data_d  = in_data;
            out_valid_d = 1'b1;
            state_d     = StWaitOut;
          end else begin
            for (int i = 0; i < 6; i++) begin
              if (dst_q == 3'(i)) begin
                regs_d[i] = in_data;
              end
            end
            pc_d    = pc_inc;
            state_d = StFetch;
          end
        end
      end

      StWaitOut: begin
        // out_data_q and out_valid_q are held until the sink accepts
        if (out_ready) begin
          out_valid_d = 1'b0;
          pc_d        = pc_inc;
          state_d     = StFetch;
        end
      end

      default: begin
        state_d = StFetch;
      end
    endcase
  end

  // State registers; reset abandons any in-flight transfer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      dst_q       <= '0;
      for (int i = 0; i < 6; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      dst_q       <= dst_d;
      for (int i = 0; i < 6; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Output drive
  always_comb begin
    prog_addr   = pc_q;
    alu_input_1 = regs_q[1];
    alu_input_2 = regs_q[2];
    in_ready    = (state_q == StWaitIn);
    out_data    = out_data_q;
    out_valid   = out_valid_q;
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a ROM and ALU model.
module tb_alu_sequencer;

  localparam logic [7:0] StartPc = 8'h20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] prog_addr;
  logic [7:0] prog_data;
  logic [7:0] alu_instruction;
  logic [7:0] alu_input_1;
  logic [7:0] alu_input_2;
  logic [7:0] alu_output;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  logic [7:0] rom [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_sequencer #(
    .UUID    (0),
    .NAME    ("seq0"),
    .RESET_PC(StartPc)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .prog_addr      (prog_addr),
    .prog_data      (prog_data),
    .alu_instruction(alu_instruction),
    .alu_input_1    (alu_input_1),
    .alu_input_2    (alu_input_2),
    .alu_output     (alu_output),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready)
  );

  // Synchronous program ROM
  always @(posedge clk) prog_data <= rom[prog_addr];

  // ALU model: OR, NAND, NOR, AND, ADD, SUB; other opcodes give zero
  always_comb begin
    alu_output = 8'h00;
    case (alu_instruction)
      8'd0: alu_output = alu_input_1 | alu_input_2;
      8'd1: alu_output = ~(alu_input_1 & alu_input_2);
      8'd2: alu_output = ~(alu_input_1 | alu_input_2);
      8'd3: alu_output = alu_input_1 & alu_input_2;
      8'd4: alu_output = alu_input_1 + alu_input_2;
      8'd5: alu_output = alu_input_1 - alu_input_2;
      default: alu_output = 8'h00;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold_reset();
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    step(1);
  endtask

  task automatic release_reset();
    step(1);
    rst = 1'b1;
  endtask

  // Wait (bounded) for an output byte, check it, then accept it
  task automatic expect_out(input string tag, input logic [7:0] exp);
    int n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    check({tag, "_valid"}, out_valid, 1);
    check(tag, out_data, exp);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- Basic program: IMM/COPY/ADD, latency, output stall ----
    hold_reset();
    rom[8'h20] = 8'h05; rom[8'h21] = 8'h81; rom[8'h22] = 8'h1A; rom[8'h23] = 8'h82;
    rom[8'h24] = 8'h44; rom[8'h25] = 8'h9E; rom[8'h26] = 8'h27; rom[8'h27] = 8'hC4;
    check("rst_pc", prog_addr, StartPc);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_alu_instr", alu_instruction, 0);
    check("rst_out_data", out_data, 0);
    release_reset();
    step(9);
    check("add_pc_before", prog_addr, 8'h24);
    check("add_alu_instr", alu_instruction, 8'h04);
    check("add_in1", alu_input_1, 8'd5);
    check("add_in2", alu_input_2, 8'd26);
    step(1);
    check("ten_cycles_pc", prog_addr, 8'h25);
    step(2);
    check("add_out_valid", out_valid, 1);
    check("add_out_data", out_data, 8'd31);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, 8'd31);
      check("stall_pc", prog_addr, 8'h25);
    end
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check("hs_valid_drop", out_valid, 0);
    check("hs_pc_inc", prog_addr, 8'h26);
    step(4);
    check("halt_pc", prog_addr, 8'h27);
    step(6);
    check("halt_pc_frozen", prog_addr, 8'h27);

    // ---- SUB, signed COND ----
    hold_reset();
    rom[8'h20] = 8'h03; rom[8'h21] = 8'h81; rom[8'h22] = 8'h05; rom[8'h23] = 8'h82;
    rom[8'h24] = 8'h45; rom[8'h25] = 8'h9E; rom[8'h26] = 8'h10; rom[8'h27] = 8'hC7;
    rom[8'h28] = 8'hC2; rom[8'h10] = 8'h11; rom[8'h11] = 8'hC4;
    release_reset();
    expect_out("sub_result", 8'hFE);
    check("sub_in1", alu_input_1, 8'd3);
    check("sub_in2", alu_input_2, 8'd5);
    step(2);
    check("imm_pc", prog_addr, 8'h27);
    step(2);
    check("cond_gt_false", prog_addr, 8'h28);
    step(2);
    check("cond_lt_taken", prog_addr, 8'h10);

    // ---- Logic ops, op6/op7, s=7, d=7, d==s, more COND, stray in_valid ----
    hold_reset();
    rom[8'h20] = 8'h35; rom[8'h21] = 8'h81; rom[8'h22] = 8'h0F; rom[8'h23] = 8'h82;
    rom[8'h24] = 8'h40; rom[8'h25] = 8'h9E; rom[8'h26] = 8'h41; rom[8'h27] = 8'h9E;
    rom[8'h28] = 8'h42; rom[8'h29] = 8'h9E; rom[8'h2A] = 8'h43; rom[8'h2B] = 8'h9E;
    rom[8'h2C] = 8'h46; rom[8'h2D] = 8'h9E; rom[8'h2E] = 8'h44; rom[8'h2F] = 8'h47;
    rom[8'h30] = 8'h9E; rom[8'h31] = 8'hB8; rom[8'h32] = 8'h86; rom[8'h33] = 8'h87;
    rom[8'h34] = 8'h89; rom[8'h35] = 8'h38; rom[8'h36] = 8'hC1; rom[8'h37] = 8'h37;
    rom[8'h38] = 8'hC5; rom[8'h39] = 8'h3A; rom[8'h3A] = 8'hC4;
    release_reset();
    in_valid = 1'b1;
    in_data  = 8'h77;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("stray_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    expect_out("or_result", 8'h3F);
    expect_out("nand_result", 8'hFA);
    expect_out("nor_result", 8'hC0);
    expect_out("and_result", 8'h05);
    expect_out("op6_result", 8'h00);
    expect_out("op7_result", 8'h00);
    expect_out("copy_s7_reg0", 8'h00);
    step(2);
    check("copy_d7_pc", prog_addr, 8'h34);
    step(2);
    check("copy_same_in1", alu_input_1, 8'h35);
    check("copy_keep_in2", alu_input_2, 8'h0F);
    step(4);
    check("cond_eq_taken", prog_addr, 8'h38);
    step(2);
    check("cond_ne_false", prog_addr, 8'h39);

    // ---- Input-to-output, input-to-register, reset mid-WAIT_OUT ----
    hold_reset();
    rom[8'h20] = 8'hB6; rom[8'h21] = 8'hB2; rom[8'h22] = 8'h96;
    release_reset();
    step(2);
    check("wait_in_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("in_ready_held", in_ready, 1);
      check("in_wait_pc", prog_addr, 8'h20);
      check("in_wait_no_out", out_valid, 0);
    end
    in_valid = 1'b1;
    in_data  = 8'hA5;
    step(1);
    in_valid = 1'b0;
    in_data  = 8'h00;
    check("io_out_valid", out_valid, 1);
    check("io_out_data", out_data, 8'hA5);
    check("io_in_ready_drop", in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("io_stall_valid", out_valid, 1);
      check("io_stall_data", out_data, 8'hA5);
      check("io_stall_pc", prog_addr, 8'h20);
    end
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check("io_hs_valid", out_valid, 0);
    check("io_hs_pc", prog_addr, 8'h21);
    step(2);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    step(1);
    in_valid = 1'b0;
    check("in_to_reg2", alu_input_2, 8'h3C);
    check("in_to_reg_pc", prog_addr, 8'h22);
    step(2);
    check("reg_out_valid", out_valid, 1);
    check("reg_out_data", out_data, 8'h3C);
    rst = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_pc", prog_addr, StartPc);
    check("async_rst_data", out_data, 0);
    step(1);
    rst = 1'b1;
    check("post_rst_reg1", alu_input_1, 0);
    check("post_rst_reg2", alu_input_2, 0);

    // ---- PC wrap and halt idiom ----
    hold_reset();
    rom[8'h20] = 8'h42; rom[8'h21] = 8'h98; rom[8'h22] = 8'hC4;
    rom[8'hFF] = 8'h00; rom[8'h00] = 8'h01; rom[8'h01] = 8'hC4;
    release_reset();
    step(6);
    check("jump_to_ff", prog_addr, 8'hFF);
    step(2);
    check("pc_wrap", prog_addr, 8'h00);
    step(2);
    check("after_wrap", prog_addr, 8'h01);
    step(6);
    check("wrap_halt", prog_addr, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
